// File: rtl/aec_pkg.sv
// Shared definitions for the parametrised expression calculator: character set,
// operator codes, token format, FSM states and operator precedence.
package aec_pkg;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_A    = 8'h61;
    localparam logic [7:0] CH_F    = 8'h66;
    localparam logic [7:0] CH_ADD  = 8'h2B;
    localparam logic [7:0] CH_SUB  = 8'h2D;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_LPAR = 8'h28;
    localparam logic [7:0] CH_RPAR = 8'h29;
    localparam logic [7:0] CH_EQ   = 8'h3D;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_LPAR = 3'd3;
    localparam logic [2:0] OP_RPAR = 3'd4;

    // is_op keeps an operand value apart from an operator code with the same bits
    typedef struct packed {
        logic       is_op;
        logic [3:0] code;
    } token_t;

    typedef struct packed {
        logic   legal;
        logic   is_eq;
        token_t tok;
    } char_info_t;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CONV, S_FLUSH, S_EVAL, S_DONE
    } state_t;

    function automatic logic [1:0] prec(input logic [2:0] op);
        case (op)
            OP_MUL:         return 2'd2;
            OP_ADD, OP_SUB: return 2'd1;
            default:        return 2'd0;
        endcase
    endfunction

    function automatic token_t op_token(input logic [2:0] op);
        return '{is_op: 1'b1, code: {1'b0, op}};
    endfunction

    function automatic char_info_t decode_char(input logic [7:0] c);
        char_info_t info;
        info           = '0;
        info.legal     = 1'b1;
        info.tok.is_op = 1'b1;
        if (c >= CH_0 && c <= CH_9) begin
            info.tok.is_op = 1'b0;
            info.tok.code  = 4'(c - CH_0);
        end else if (c >= CH_A && c <= CH_F) begin
            info.tok.is_op = 1'b0;
            info.tok.code  = 4'(c - CH_A + 8'd10);
        end else begin
            case (c)
                CH_ADD:  info.tok.code = {1'b0, OP_ADD};
                CH_SUB:  info.tok.code = {1'b0, OP_SUB};
                CH_MUL:  info.tok.code = {1'b0, OP_MUL};
                CH_LPAR: info.tok.code = {1'b0, OP_LPAR};
                CH_RPAR: info.tok.code = {1'b0, OP_RPAR};
                CH_EQ:   info.is_eq    = 1'b1;
                default: info.legal    = 1'b0;
            endcase
        end
        return info;
    endfunction

endpackage

// File: rtl/aec_stack.sv
// LIFO used for both the operator stack and the value stack.
// push+pop replaces the top; push+pop2 collapses the top two entries into one.
module aec_stack
    import aec_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   pop2,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           top,
    output logic [W-1:0]           below,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] cnt;
    logic [PW-1:0] base;
    logic [AW-1:0] wr_idx;

    always_comb begin
        base = cnt;
        if (pop2) begin
            base = cnt - PW'(2);
        end else if (pop) begin
            base = cnt - PW'(1);
        end
        wr_idx = AW'(base);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= base + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_idx] <= din;
        end
    end

    assign top   = mem[AW'(cnt - PW'(1))];
    assign below = mem[AW'(cnt - PW'(2))];
    assign count = cnt;
    assign empty = (cnt == '0);

endmodule

// File: rtl/aec_param.sv
// Infix expression calculator: captures tokens, converts to postfix with a
// shunting-yard pass, then evaluates the postfix on a value stack.
module aec_param
    import aec_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready,
    input  logic [7:0]        ascii_in,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic              error
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    state_t        state, next_state;
    token_t        tok_buf [DEPTH];
    token_t        pf_buf  [DEPTH];
    logic [PW-1:0] tok_cnt, pf_cnt, rd_idx, tok_base;
    logic          err, err_base;
    char_info_t    ch;
    token_t        cur_tok, pf_tok;
    logic          start, capture, store_tok;
    logic          rd_adv, rd_rewind, pf_wr, set_err;

    logic              op_push, op_pop, op_empty;
    logic [2:0]        op_top, op_below;
    logic [PW-1:0]     op_count;
    logic              val_push, val_pop2, val_empty;
    logic [DATA_W-1:0] val_din, val_top, val_below, alu_out;
    logic [PW-1:0]     val_count;
    logic              unused_ok;

    aec_stack #(.W(3), .DEPTH(DEPTH)) op_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .push  (op_push),
        .pop   (op_pop),
        .pop2  (1'b0),
        .din   (cur_tok.code[2:0]),
        .top   (op_top),
        .below (op_below),
        .count (op_count),
        .empty (op_empty)
    );

    aec_stack #(.W(DATA_W), .DEPTH(DEPTH)) val_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .push  (val_push),
        .pop   (1'b0),
        .pop2  (val_pop2),
        .din   (val_din),
        .top   (val_top),
        .below (val_below),
        .count (val_count),
        .empty (val_empty)
    );

    assign unused_ok = &{1'b0, op_below, op_count, val_empty};

    // The ready-cycle char belongs to the new expression, so counters restart from zero in that same cycle
    assign ch        = decode_char(ascii_in);
    assign start     = (state == S_IDLE) && ready;
    assign capture   = start || (state == S_READ);
    assign tok_base  = start ? '0 : tok_cnt;
    assign err_base  = start ? 1'b0 : err;
    assign store_tok = capture && ch.legal && !ch.is_eq && (tok_base != PW'(DEPTH));
    assign cur_tok   = (state == S_EVAL) ? pf_buf[AW'(rd_idx)] : tok_buf[AW'(rd_idx)];

    always_comb begin
        alu_out = '0;
        case (cur_tok.code[2:0])
            OP_ADD:  alu_out = val_below + val_top;
            OP_SUB:  alu_out = val_below - val_top;
            OP_MUL:  alu_out = val_below * val_top;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        op_push    = 1'b0;
        op_pop     = 1'b0;
        val_push   = 1'b0;
        val_pop2   = 1'b0;
        val_din    = DATA_W'(cur_tok.code);
        pf_wr      = 1'b0;
        pf_tok     = cur_tok;
        rd_adv     = 1'b0;
        rd_rewind  = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ready) next_state = ch.is_eq ? S_CONV : S_READ;
            end
            S_READ: begin
                if (ch.is_eq) next_state = S_CONV;
            end
            S_CONV: begin
                if (err) begin
                    next_state = S_DONE;
                end else if (rd_idx == tok_cnt) begin
                    next_state = S_FLUSH;
                end else if (!cur_tok.is_op) begin
                    pf_wr  = 1'b1;
                    rd_adv = 1'b1;
                end else begin
                    case (cur_tok.code[2:0])
                        OP_LPAR: begin
                            op_push = 1'b1;
                            rd_adv  = 1'b1;
                        end
                        OP_RPAR: begin
                            if (op_empty) begin
                                set_err    = 1'b1;
                                next_state = S_DONE;
                            end else if (op_top == OP_LPAR) begin
                                op_pop = 1'b1;
                                rd_adv = 1'b1;
                            end else begin
                                op_pop = 1'b1;
                                pf_wr  = 1'b1;
                                pf_tok = op_token(op_top);
                            end
                        end
                        default: begin
                            if (!op_empty && op_top != OP_LPAR &&
                                prec(op_top) >= prec(cur_tok.code[2:0])) begin
                                op_pop = 1'b1;
                                pf_wr  = 1'b1;
                                pf_tok = op_token(op_top);
                            end else begin
                                op_push = 1'b1;
                                rd_adv  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_FLUSH: begin
                if (op_empty) begin
                    next_state = S_EVAL;
                    rd_rewind  = 1'b1;
                end else if (op_top == OP_LPAR) begin
                    set_err    = 1'b1;
                    next_state = S_DONE;
                end else begin
                    op_pop = 1'b1;
                    pf_wr  = 1'b1;
                    pf_tok = op_token(op_top);
                end
            end
            S_EVAL: begin
                if (rd_idx == pf_cnt) begin
                    set_err    = (val_count != PW'(1));
                    next_state = S_DONE;
                end else if (!cur_tok.is_op) begin
                    val_push = 1'b1;
                    rd_adv   = 1'b1;
                end else if (val_count < PW'(2)) begin
                    set_err    = 1'b1;
                    next_state = S_DONE;
                end else begin
                    val_pop2 = 1'b1;
                    val_push = 1'b1;
                    val_din  = alu_out;
                    rd_adv   = 1'b1;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_cnt <= '0;
            pf_cnt  <= '0;
            rd_idx  <= '0;
            err     <= 1'b0;
            valid   <= 1'b0;
            result  <= '0;
            error   <= 1'b0;
        end else begin
            tok_cnt <= store_tok ? tok_base + 1'b1 : tok_base;
            err     <= err_base | set_err | (capture && !ch.legal) |
                       (store_tok && tok_base == PW'(DEPTH - 1));
            if (start) begin
                pf_cnt <= '0;
            end else if (pf_wr) begin
                pf_cnt <= pf_cnt + 1'b1;
            end
            if (start || rd_rewind) begin
                rd_idx <= '0;
            end else if (rd_adv) begin
                rd_idx <= rd_idx + 1'b1;
            end
            valid <= (state == S_DONE);
            if (state == S_DONE) begin
                result <= err ? '0 : val_top;
                error  <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_tok) tok_buf[AW'(tok_base)] <= ch.tok;
        if (pf_wr)     pf_buf[AW'(pf_cnt)]    <= pf_tok;
    end

endmodule
